dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the 4096 × 32-bit data memory `ram`. It shares the single memory port between port 0 (CPU MEM stage) and port 1 (debug/program loader). Each access is sequenced through a fixed issue/wait/respond state machine and completed with a one-cycle ack pulse. It sits between the requesters and `ram`, and is the only block that drives `ram` store/load strobes.

---
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU MEM stage
// (port 0) and the debug/program loader (port 1). Every access runs through
// IDLE -> ISSUE -> WAIT -> RESP and finishes with a one-cycle ack pulse.
// Optional feature: define DMEM_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking; otherwise port 0 always wins a tie.
module dmem_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy,
   output logic [ADDR_W-1:0] data_memory_address,
   output logic [DATA_W-1:0] data_memory_data_in,
   output logic              store,
   output logic              load,
   input  logic [DATA_W-1:0] data_memory_data_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              gnt_id_q, gnt_id_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              last_grant_q, last_grant_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              winner;

   // Pick which port gets the memory when the sequencer is idle.
   always_comb begin
      winner = 1'b0;
      if (req0 && req1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         winner = ~last_grant_q;
`else
         winner = 1'b0;
`endif
      end else if (req1) begin
         winner = 1'b1;
      end
   end

   // Next-state logic: latch the winner in IDLE, capture load data in WAIT.
   always_comb begin
      state_d      = state_q;
      gnt_id_d     = gnt_id_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      last_grant_d = last_grant_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               gnt_id_d     = winner;
               last_grant_d = winner;
               we_d         = winner ? we1 : we0;
               addr_d       = winner ? addr1 : addr0;
               wdata_d      = winner ? wdata1 : wdata0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (!we_q) begin
               if (gnt_id_q) begin
                  rdata1_d = data_memory_data_out;
               end else begin
                  rdata0_d = data_memory_data_out;
               end
            end
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and latched-request registers; reset clears everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         gnt_id_q     <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         last_grant_q <= 1'b1;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         gnt_id_q     <= gnt_id_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         last_grant_q <= last_grant_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   // Strobes and acks are decoded straight from state so reset kills them immediately.
   always_comb begin
      store               = (state_q == ISSUE) && we_q;
      load                = (state_q == ISSUE) && !we_q;
      ack0                = (state_q == RESP) && !gnt_id_q;
      ack1                = (state_q == RESP) && gnt_id_q;
      busy                = (state_q != IDLE);
      data_memory_address = addr_q;
      data_memory_data_in = wdata_q;
      rdata0              = rdata0_q;
      rdata1              = rdata1_q;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: drives dmem_arbiter against a behavioural ram and a
// transaction-level reference (expected memory image, per-port rdata and the
// last winner). Build with DMEM_ARB_ROUND_ROBIN_EN to exercise round robin.
module tb_dmem_arbiter;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              req0, we0, req1, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              ack0, ack1, busy, store, load;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic [ADDR_W-1:0] data_memory_address;
   logic [DATA_W-1:0] data_memory_data_in, data_memory_data_out;

   logic [DATA_W-1:0] ram_mem [0:4095];
   logic [DATA_W-1:0] ref_mem [0:4095];
   int                m_last_grant;
   logic [DATA_W-1:0] m_rdata0, m_rdata1;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        r0, r1, w0, w1;
      logic [11:0] a0, a1;
      logic [31:0] d0, d1, exp_rd0, exp_rd1;
   } vec_t;

   vec_t tbl [6];

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
      .busy(busy),
      .data_memory_address(data_memory_address),
      .data_memory_data_in(data_memory_data_in),
      .store(store), .load(load),
      .data_memory_data_out(data_memory_data_out)
   );

   always #5 clk = ~clk;

   // Behavioural ram: registered read, write on the store strobe.
   always @(posedge clk) begin
      if (load) data_memory_data_out <= ram_mem[data_memory_address];
      if (store) ram_mem[data_memory_address] = data_memory_data_in;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Runs one or two simultaneous requests from an IDLE negedge and returns at
   // the IDLE negedge after the last ack. drop_cyc drops and scrambles the
   // requests at that cycle (single requests only).
   task automatic applyStimulus(input logic r0, input logic r1, input logic w0, input logic w1,
                                input logic [11:0] a0, input logic [11:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1, input int drop_cyc);
      int          order[$];
      logic        pw [2];
      logic [11:0] pa [2];
      logic [31:0] pd [2];
      int          n, k, p, first, st_cnt, ld_cnt, exp_st, exp_ld;
      pw[0] = w0; pw[1] = w1; pa[0] = a0; pa[1] = a1; pd[0] = d0; pd[1] = d1;
      if (r0 && r1) begin
         first = RR_EN ? ((m_last_grant == 1) ? 0 : 1) : 0;
         order.push_back(first);
         order.push_back(1 - first);
      end else if (r0) begin
         order.push_back(0);
      end else if (r1) begin
         order.push_back(1);
      end
      n = order.size();
      exp_st = 0; exp_ld = 0;
      foreach (order[i]) begin
         p = order[i];
         if (pw[p]) begin
            ref_mem[pa[p]] = pd[p];
            exp_st++;
         end else begin
            exp_ld++;
            if (p == 0) m_rdata0 = ref_mem[pa[p]];
            else        m_rdata1 = ref_mem[pa[p]];
         end
         m_last_grant = p;
      end
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      st_cnt = 0; ld_cnt = 0;
      for (int c = 1; c <= 4 * n; c++) begin
         @(negedge clk);
         k = (c - 1) / 4;
         p = order[k];
         if (store) st_cnt++;
         if (load) ld_cnt++;
         checkOutput("store", store, (c % 4 == 1) && pw[p]);
         checkOutput("load", load, (c % 4 == 1) && !pw[p]);
         checkOutput("busy", busy, c % 4 != 0);
         checkOutput("ack0", ack0, (c % 4 == 3) && (p == 0));
         checkOutput("ack1", ack1, (c % 4 == 3) && (p == 1));
         if (c % 4 == 1) begin
            checkOutput("mem_addr", data_memory_address, pa[p]);
            if (pw[p]) checkOutput("mem_din", data_memory_data_in, pd[p]);
         end
         if (c % 4 == 3) begin
            if (!pw[p]) begin
               if (p == 0) checkOutput("rdata0", rdata0, m_rdata0);
               else        checkOutput("rdata1", rdata1, m_rdata1);
            end
            if (p == 0) req0 = 1'b0;
            else        req1 = 1'b0;
         end
         if (c == drop_cyc) begin
            req0 = 1'b0; we0 = ~we0; addr0 = ~addr0; wdata0 = ~wdata0;
            req1 = 1'b0; we1 = ~we1; addr1 = ~addr1; wdata1 = ~wdata1;
         end
      end
      checkOutput("store_pulses", st_cnt, exp_st);
      checkOutput("load_pulses", ld_cnt, exp_ld);
      checkOutput("rdata0_end", rdata0, m_rdata0);
      checkOutput("rdata1_end", rdata1, m_rdata1);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ack0"}, ack0, 0);
      checkOutput({tag, "_ack1"}, ack1, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_store"}, store, 0);
      checkOutput({tag, "_load"}, load, 0);
      checkOutput({tag, "_rdata0"}, rdata0, 0);
      checkOutput({tag, "_rdata1"}, rdata1, 0);
      checkOutput({tag, "_addr"}, data_memory_address, 0);
      checkOutput({tag, "_din"}, data_memory_data_in, 0);
   endtask

   initial begin
      int          sel, drop;
      logic [11:0] ra0, ra1;
      logic        rw0, rw1;
      for (int i = 0; i < 4096; i++) begin
         ram_mem[i] = '0;
         ref_mem[i] = '0;
      end
      m_last_grant = 1; m_rdata0 = '0; m_rdata1 = '0;
      rst = 1'b1;
      req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;

      tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 12'd123, 12'd0,   32'h1234cdef, 32'd0,        32'd0,        32'd0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 12'd123, 12'd0,   32'd0,        32'd0,        32'h1234cdef, 32'd0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'd0,   12'hfff, 32'd0,        32'hffffffff, 32'h1234cdef, 32'd0};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'd0,   12'hfff, 32'd0,        32'd0,        32'h1234cdef, 32'hffffffff};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 12'h010, 12'd123, 32'ha5a50001, 32'd0,        32'h1234cdef, 32'h1234cdef};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h010, 12'hfff, 32'd0,        32'd0,        32'ha5a50001, 32'hffffffff};

      #2;
      checkAllZero("reset");
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] directed table");
      foreach (tbl[i]) begin
         applyStimulus(tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1, tbl[i].a0, tbl[i].a1,
                       tbl[i].d0, tbl[i].d1, -1);
         checkOutput("tbl_rdata0", rdata0, tbl[i].exp_rd0);
         checkOutput("tbl_rdata1", rdata1, tbl[i].exp_rd1);
      end

      $display("[TB] request dropped in ISSUE");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'd123, 12'd0, 32'd0, 32'd0, 1);

      $display("[TB] randomized accesses");
      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(1, 3);
         ra0 = ($urandom_range(0, 4) == 0) ? 12'hfff : 12'($urandom_range(0, 15));
         ra1 = ($urandom_range(0, 4) == 0) ? 12'hfff : 12'($urandom_range(0, 15));
         rw0 = 1'($urandom_range(0, 1));
         rw1 = 1'($urandom_range(0, 1));
         drop = (sel != 3 && $urandom_range(0, 3) == 0) ? 1 : -1;
         applyStimulus(sel[0], sel[1], rw0, rw1, ra0, ra1, $urandom, $urandom, drop);
      end

      $display("[TB] reset during WAIT of a load");
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'd123; wdata0 = '0; req1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 checkAllZero("midrst");
      req0 = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checkOutput("midrst_noack0", ack0, 0);
      end
      rst = 1'b0;
      m_last_grant = 1; m_rdata0 = '0; m_rdata1 = '0;
      @(negedge clk);
      checkOutput("postrst_busy", busy, 0);
      checkOutput("postrst_ack0", ack0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'd123, 12'd0, 32'd0, 32'd0, -1);
      checkOutput("reissue_rdata0", rdata0, 32'h1234cdef);

      $display("[TB] both requests held continuously");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'd123;
      req1 = 1'b1; we1 = 1'b0; addr1 = 12'hfff;
      for (int c = 1; c <= 19; c++) begin
         @(negedge clk);
         if (c <= 15) begin
            checkOutput("hold_ack0", ack0, (c % 4 == 3) && (!RR_EN || ((c / 4) % 2 == 0)));
            checkOutput("hold_ack1", ack1, (c % 4 == 3) && RR_EN && ((c / 4) % 2 == 1));
         end else begin
            checkOutput("tail_ack0", ack0, 0);
            checkOutput("tail_ack1", ack1, c == 19);
         end
         if (c == 15) req0 = 1'b0;
         if (c == 19) req1 = 1'b0;
      end
      @(negedge clk);
      checkOutput("final_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
